// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU op codes and ID/EX bundle types.
// Imported by the ID/EX stage, its decoder and its interface users.
package mips_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       a_shamt;
    logic       b_imm;
    logic       imm_zext;
    logic       rd_is_rt;
    logic       reads_rt;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_ctrl;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
    logic       a_shamt;
    logic       b_imm;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] shamt;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: pipeline control, ID inputs, bypass inputs, EX outputs.
// master = pipeline driving the stage, slave = the id_ex_stage itself.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_rs_data;
  logic [XLEN-1:0] id_rt_data;
  logic            exmem_reg_write;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_store_data;
  logic            ex_illegal;
  logic            hazard_stall;

  modport master (
    output stall, flush, id_valid, id_instr,
    output id_rs_data, id_rt_data,
    output exmem_reg_write, exmem_rd, exmem_result,
    output memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_ctrl, ex_valid,
    input  ex_reg_write, ex_mem_read, ex_mem_write,
    input  ex_branch, ex_rd, ex_store_data,
    input  ex_illegal, hazard_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_instr,
    input  id_rs_data, id_rt_data,
    input  exmem_reg_write, exmem_rd, exmem_result,
    input  memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_ctrl, ex_valid,
    output ex_reg_write, ex_mem_read, ex_mem_write,
    output ex_branch, ex_rd, ex_store_data,
    output ex_illegal, hazard_stall
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode into ALU op, operand selects and controls.
// Ports: opcode, funct in; dec (dec_t) out. Unknown encodings set illegal.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  logic r_op, r_add, r_sub, r_and, r_or, r_slt, r_sll, r_srl;
  logic i_add, i_and, i_or, i_slt, i_br;

  assign r_op  = opcode == OP_RTYPE;
  assign r_add = r_op && (funct == FN_ADD || funct == FN_ADDU);
  assign r_sub = r_op && (funct == FN_SUB || funct == FN_SUBU);
  assign r_and = r_op && funct == FN_AND;
  assign r_or  = r_op && funct == FN_OR;
  assign r_slt = r_op && funct == FN_SLT;
  assign r_sll = r_op && funct == FN_SLL;
  assign r_srl = r_op && funct == FN_SRL;
  assign i_add = opcode == OP_ADDI || opcode == OP_ADDIU
              || opcode == OP_LW || opcode == OP_SW;
  assign i_and = opcode == OP_ANDI;
  assign i_or  = opcode == OP_ORI;
  assign i_slt = opcode == OP_SLTI;
  assign i_br  = opcode == OP_BEQ || opcode == OP_BNE;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      r_add: dec.alu_ctrl = ALU_ADD;
      r_sub: dec.alu_ctrl = ALU_SUB;
      r_and: dec.alu_ctrl = ALU_AND;
      r_or:  dec.alu_ctrl = ALU_OR;
      r_slt: dec.alu_ctrl = ALU_SLT;
      r_sll: begin
        dec.alu_ctrl = ALU_SLL;
        dec.a_shamt  = 1'b1;
      end
      r_srl: begin
        dec.alu_ctrl = ALU_SRL;
        dec.a_shamt  = 1'b1;
      end
      i_add: begin
        dec.alu_ctrl = ALU_ADD;
        dec.b_imm    = 1'b1;
      end
      i_and: begin
        dec.alu_ctrl = ALU_AND;
        dec.b_imm    = 1'b1;
        dec.imm_zext = 1'b1;
      end
      i_or: begin
        dec.alu_ctrl = ALU_OR;
        dec.b_imm    = 1'b1;
        dec.imm_zext = 1'b1;
      end
      i_slt: begin
        dec.alu_ctrl = ALU_SLT;
        dec.b_imm    = 1'b1;
      end
      i_br: begin
        dec.alu_ctrl = ALU_SUB;
        dec.branch   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (!dec.illegal) begin
      dec.rd_is_rt  = !r_op;
      dec.reads_rt  = r_op || i_br || opcode == OP_SW;
      dec.reg_write = !(i_br || opcode == OP_SW);
      dec.mem_read  = opcode == OP_LW;
      dec.mem_write = opcode == OP_SW;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: decode, stage register, EX operand bypass, load-use stall.
// Ports: clk, rst_n, bus (id_ex_stage_if.slave). Bypass: ID_EX_FWD_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  dec_t            dec;
  id_ex_t          nxt, ex;
  logic [4:0]      id_rs, id_rt, id_dst;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] rs_q, rt_q, imm_q;
  logic [XLEN-1:0] rs_n, rt_n, imm_n;
  logic [XLEN-1:0] rs_fwd, rt_fwd;
  logic            hit_ex, hit_mem;

  alu_decoder u_dec (
    .opcode (bus.id_instr[31:26]),
    .funct  (bus.id_instr[5:0]),
    .dec    (dec)
  );

  assign id_rs  = bus.id_instr[25:21];
  assign id_rt  = bus.id_instr[20:16];
  assign id_dst = dec.rd_is_rt ? id_rt : bus.id_instr[15:11];
  assign id_imm = dec.imm_zext
    ? {{(XLEN-16){1'b0}}, bus.id_instr[15:0]}
    : {{(XLEN-16){bus.id_instr[15]}}, bus.id_instr[15:0]};

  // An invalid ID slot becomes an all-zero bubble, data included.
  always_comb begin
    nxt   = '0;
    rs_n  = '0;
    rt_n  = '0;
    imm_n = '0;
    if (bus.id_valid) begin
      nxt.valid     = 1'b1;
      nxt.alu_ctrl  = dec.alu_ctrl;
      nxt.reg_write = dec.reg_write && id_dst != 5'd0;
      nxt.mem_read  = dec.mem_read;
      nxt.mem_write = dec.mem_write;
      nxt.branch    = dec.branch;
      nxt.illegal   = dec.illegal;
      nxt.a_shamt   = dec.a_shamt;
      nxt.b_imm     = dec.b_imm;
      nxt.rd        = nxt.reg_write ? id_dst : 5'd0;
      nxt.rs        = id_rs;
      nxt.rt        = id_rt;
      nxt.shamt     = bus.id_instr[10:6];
      rs_n          = bus.id_rs_data;
      rt_n          = bus.id_rt_data;
      imm_n         = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex    <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else if (bus.flush) begin
      ex    <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else if (!bus.stall) begin
      ex    <= nxt;
      rs_q  <= rs_n;
      rt_q  <= rt_n;
      imm_q <= imm_n;
    end
  end

  always_comb begin
    rs_fwd = rs_q;
    rt_fwd = rt_q;
`ifdef ID_EX_FWD_EN
    if (bus.exmem_reg_write && bus.exmem_rd == ex.rs && ex.rs != 5'd0)
      rs_fwd = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd == ex.rs && ex.rs != 5'd0)
      rs_fwd = bus.memwb_result;
    if (bus.exmem_reg_write && bus.exmem_rd == ex.rt && ex.rt != 5'd0)
      rt_fwd = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd == ex.rt && ex.rt != 5'd0)
      rt_fwd = bus.memwb_result;
`endif
  end

`ifndef ID_EX_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{bus.exmem_result, bus.memwb_reg_write,
                        bus.memwb_rd, bus.memwb_result, ex.rs, ex.rt};
`endif

  assign bus.alu_a = ex.a_shamt ? {{(XLEN-5){1'b0}}, ex.shamt} : rs_fwd;
  assign bus.alu_b = ex.b_imm ? imm_q : rt_fwd;
  assign bus.alu_ctrl      = ex.alu_ctrl;
  assign bus.ex_valid      = ex.valid;
  assign bus.ex_reg_write  = ex.reg_write;
  assign bus.ex_mem_read   = ex.mem_read;
  assign bus.ex_mem_write  = ex.mem_write;
  assign bus.ex_branch     = ex.branch;
  assign bus.ex_rd         = ex.rd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.ex_illegal    = ex.illegal;

  // Does the ID instruction read the given register?
  assign hit_ex = bus.id_valid && ex.rd != 5'd0
    && (ex.rd == id_rs || (dec.reads_rt && ex.rd == id_rt));
  assign hit_mem = bus.id_valid && bus.exmem_rd != 5'd0
    && (bus.exmem_rd == id_rs || (dec.reads_rt && bus.exmem_rd == id_rt));

`ifdef ID_EX_FWD_EN
  assign bus.hazard_stall = ex.valid && ex.mem_read && hit_ex;
  logic unused_mem;
  assign unused_mem = hit_mem;
`else
  // Without bypass every in-flight producer must drain to the register file.
  assign bus.hazard_stall = (ex.valid && (ex.mem_read || ex.reg_write) && hit_ex)
                         || (bus.exmem_reg_write && hit_mem);
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus random stimulus
// checked against a behavioural model of decode, bypass and hazard rules.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model of what sits in EX.
  logic        ex_v;
  logic [31:0] ex_instr, ex_rs_d, ex_rt_d;

  typedef struct packed {
    logic        ok;
    logic [3:0]  op;
    logic        sh;
    logic        useimm;
    logic [31:0] imm;
    logic        wr;
    logic        ld;
    logic        st;
    logic        br;
    logic        rtsrc;
    logic [4:0]  dst;
  } m_t;

  function automatic m_t mdec(logic [31:0] ins);
    m_t m;
    logic [5:0] o, f;
    m = '0;
    o = ins[31:26];
    f = ins[5:0];
    m.ok = 1'b1;
    if (o == 6'h00) begin
      m.rtsrc = 1'b1;
      m.wr = 1'b1;
      m.dst = ins[15:11];
      case (f)
        6'h20, 6'h21: m.op = 4'd0;
        6'h22, 6'h23: m.op = 4'd1;
        6'h24: m.op = 4'd2;
        6'h25: m.op = 4'd3;
        6'h2A: m.op = 4'd6;
        6'h00: begin m.op = 4'd4; m.sh = 1'b1; end
        6'h02: begin m.op = 4'd5; m.sh = 1'b1; end
        default: m.ok = 1'b0;
      endcase
    end else begin
      m.dst = ins[20:16];
      m.useimm = 1'b1;
      m.imm = {{16{ins[15]}}, ins[15:0]};
      m.wr = 1'b1;
      case (o)
        6'h08, 6'h09: m.op = 4'd0;
        6'h23: m.ld = 1'b1;
        6'h2B: begin m.st = 1'b1; m.wr = 1'b0; m.rtsrc = 1'b1; end
        6'h0C: begin m.op = 4'd2; m.imm = {16'h0, ins[15:0]}; end
        6'h0D: begin m.op = 4'd3; m.imm = {16'h0, ins[15:0]}; end
        6'h0A: m.op = 4'd6;
        6'h04, 6'h05: begin
          m.op = 4'd1; m.br = 1'b1; m.wr = 1'b0;
          m.useimm = 1'b0; m.rtsrc = 1'b1;
        end
        default: m.ok = 1'b0;
      endcase
    end
    if (!m.ok) m = '0;
    if (m.dst == 5'd0) m.wr = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] mfwd(logic [4:0] src, logic [31:0] d);
`ifdef ID_EX_FWD_EN
    if (src != 0 && bus.exmem_reg_write && bus.exmem_rd == src)
      return bus.exmem_result;
    if (src != 0 && bus.memwb_reg_write && bus.memwb_rd == src)
      return bus.memwb_result;
`endif
    return d;
  endfunction

  function automatic logic mreads(logic [4:0] r);
    m_t d;
    d = mdec(bus.id_instr);
    if (!bus.id_valid || r == 5'd0) return 1'b0;
    return r == bus.id_instr[25:21] || (d.rtsrc && r == bus.id_instr[20:16]);
  endfunction

  function automatic logic mhaz();
    m_t e;
    logic h;
    e = mdec(ex_instr);
    h = ex_v && e.ld && mreads(e.dst);
`ifndef ID_EX_FWD_EN
    h = h || (ex_v && e.wr && mreads(e.dst));
    h = h || (bus.exmem_reg_write && mreads(bus.exmem_rd));
`endif
    return h;
  endfunction

  function automatic logic [111:0] mexp();
    m_t m;
    logic [31:0] a, b, rsv, rtv;
    if (!ex_v) return {111'h0, mhaz()};
    m = mdec(ex_instr);
    rsv = mfwd(ex_instr[25:21], ex_rs_d);
    rtv = mfwd(ex_instr[20:16], ex_rt_d);
    a = m.sh ? {27'h0, ex_instr[10:6]} : rsv;
    b = m.useimm ? m.imm : rtv;
    return {a, b, m.op, 1'b1, m.wr, m.ld, m.st, m.br,
            (m.wr ? m.dst : 5'd0), rtv, !m.ok, mhaz()};
  endfunction

  function automatic logic [111:0] actual();
    return {bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.ex_valid,
            bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
            bus.ex_branch, bus.ex_rd, bus.ex_store_data,
            bus.ex_illegal, bus.hazard_stall};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                            6'h25, 6'h2A, 6'h00, 6'h02};
    logic [5:0] ops [9] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                            6'h23, 6'h2B, 6'h04, 6'h05};
    logic [4:0] rs, rt, rd, sa;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    sa = 5'($urandom);
    if ($urandom_range(0, 1) == 0)
      return {6'h00, rs, rt, rd, sa, fns[$urandom_range(0, 8)]};
    return {ops[$urandom_range(0, 8)], rs, rt, 16'($urandom)};
  endfunction

  task automatic mclear();
    ex_v = 1'b0;
    ex_instr = '0;
    ex_rs_d = '0;
    ex_rt_d = '0;
  endtask

  task automatic step();
    if (bus.flush) mclear();
    else if (!bus.stall) begin
      ex_v = bus.id_valid;
      ex_instr = bus.id_valid ? bus.id_instr : 32'h0;
      ex_rs_d = bus.id_valid ? bus.id_rs_data : 32'h0;
      ex_rt_d = bus.id_valid ? bus.id_rt_data : 32'h0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.id_valid = 0; bus.id_instr = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mclear();
    #3;
    total++;
    if (actual() !== 112'h0)
      $display("FAIL reset_outputs got %h want 0", actual());
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (bus.ex_valid !== 1'b0 || bus.alu_ctrl !== 4'h0)
      $display("FAIL reset_idle got v=%b op=%h want 0", bus.ex_valid, bus.alu_ctrl);
    else passed++;
  endtask

  task automatic test_add();
    bus.id_valid = 1;
    bus.id_instr = {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    bus.id_rs_data = 5;
    bus.id_rt_data = 7;
    step();
    bus.id_valid = 0;
    total++;
    if ({bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.ex_rd, bus.ex_reg_write}
        !== {4'h0, 32'd5, 32'd7, 5'd3, 1'b1})
      $display("FAIL add got op=%h a=%0d b=%0d rd=%0d wr=%b want 0/5/7/3/1",
               bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.ex_rd, bus.ex_reg_write);
    else passed++;
  endtask

  task automatic test_imm();
    bus.id_valid = 1;
    bus.id_instr = {6'h0, 5'd0, 5'd2, 5'd4, 5'd3, 6'h00};
    bus.id_rt_data = 32'h1;
    step();
    total++;
    if ({bus.alu_ctrl, bus.alu_a, bus.alu_b} !== {4'h4, 32'd3, 32'h1})
      $display("FAIL sll got op=%h a=%h b=%h want 4/3/1",
               bus.alu_ctrl, bus.alu_a, bus.alu_b);
    else passed++;
    bus.id_instr = {6'h0C, 5'd1, 5'd5, 16'hFFFF};
    step();
    total++;
    if ({bus.alu_ctrl, bus.alu_b} !== {4'h2, 32'h0000FFFF})
      $display("FAIL andi got op=%h b=%h want 2/0000ffff", bus.alu_ctrl, bus.alu_b);
    else passed++;
    bus.id_instr = {6'h0A, 5'd1, 5'd5, 16'hFFFF};
    step();
    bus.id_valid = 0;
    total++;
    if ({bus.alu_ctrl, bus.alu_b} !== {4'h6, 32'hFFFFFFFF})
      $display("FAIL slti got op=%h b=%h want 6/ffffffff", bus.alu_ctrl, bus.alu_b);
    else passed++;
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_a;
    bus.id_valid = 1;
    bus.id_instr = {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    bus.id_rs_data = 5;
    bus.id_rt_data = 7;
    step();
    bus.id_valid = 0;
    bus.exmem_reg_write = 1; bus.exmem_rd = 1; bus.exmem_result = 32'h10;
    bus.memwb_reg_write = 1; bus.memwb_rd = 1; bus.memwb_result = 32'h20;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'h10;
`else
    exp_a = 32'd5;
`endif
    total++;
    if (bus.alu_a !== exp_a)
      $display("FAIL fwd_priority got %h want %h", bus.alu_a, exp_a);
    else passed++;
    bus.exmem_reg_write = 0;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'h20;
`endif
    total++;
    if (bus.alu_a !== exp_a)
      $display("FAIL fwd_memwb got %h want %h", bus.alu_a, exp_a);
    else passed++;
    bus.exmem_reg_write = 1; bus.exmem_rd = 0;
    bus.memwb_rd = 0;
    #1;
    total++;
    if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7)
      $display("FAIL fwd_r0 got a=%h b=%h want 5/7", bus.alu_a, bus.alu_b);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_load_use();
    logic exp_h;
    bus.id_valid = 1;
    bus.id_instr = {6'h23, 5'd1, 5'd2, 16'h0};
    bus.id_rs_data = 32'h100;
    step();
    bus.id_instr = {6'h0, 5'd2, 5'd2, 5'd3, 5'd0, 6'h20};
    bus.id_rs_data = 32'hDEAD0000;
    bus.id_rt_data = 32'hDEAD0000;
    #1;
    total++;
    if (bus.hazard_stall !== 1'b1)
      $display("FAIL loaduse_stall got %b want 1", bus.hazard_stall);
    else passed++;
    bus.flush = 1;
    step();
    bus.exmem_reg_write = 1; bus.exmem_rd = 2; bus.exmem_result = 32'h100;
    #1;
`ifdef ID_EX_FWD_EN
    exp_h = 1'b0;
`else
    exp_h = 1'b1;
`endif
    total++;
    if (bus.ex_valid !== 1'b0 || bus.hazard_stall !== exp_h)
      $display("FAIL loaduse_bubble got v=%b h=%b want 0/%b",
               bus.ex_valid, bus.hazard_stall, exp_h);
    else passed++;
`ifndef ID_EX_FWD_EN
    step();
    bus.exmem_reg_write = 0;
    bus.memwb_reg_write = 1; bus.memwb_rd = 2; bus.memwb_result = 32'hCAFE;
    bus.id_rs_data = 32'hCAFE;
    bus.id_rt_data = 32'hCAFE;
    #1;
    total++;
    if (bus.hazard_stall !== 1'b0)
      $display("FAIL loaduse_release got %b want 0", bus.hazard_stall);
    else passed++;
`endif
    bus.flush = 0;
    step();
    bus.id_valid = 0;
    bus.exmem_reg_write = 0;
    bus.memwb_reg_write = 1; bus.memwb_rd = 2; bus.memwb_result = 32'hCAFE;
    #1;
    total++;
    if ({bus.ex_valid, bus.alu_a, bus.alu_b} !== {1'b1, 32'hCAFE, 32'hCAFE})
      $display("FAIL loaduse_data got v=%b a=%h b=%h want 1/cafe/cafe",
               bus.ex_valid, bus.alu_a, bus.alu_b);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_flush_stall();
    bus.id_valid = 1;
    bus.id_instr = {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    bus.id_rs_data = 5;
    bus.id_rt_data = 7;
    step();
    bus.stall = 1;
    bus.id_instr = {6'h0, 5'd0, 5'd2, 5'd4, 5'd3, 6'h00};
    step();
    total++;
    if ({bus.alu_ctrl, bus.alu_a, bus.ex_rd} !== {4'h0, 32'd5, 5'd3})
      $display("FAIL stall_hold got op=%h a=%h rd=%0d want 0/5/3",
               bus.alu_ctrl, bus.alu_a, bus.ex_rd);
    else passed++;
    bus.flush = 1;
    step();
    total++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
         bus.ex_branch, bus.alu_ctrl, bus.ex_rd} !== 14'h0)
      $display("FAIL flush_stall got v=%b wr=%b op=%h rd=%0d want 0",
               bus.ex_valid, bus.ex_reg_write, bus.alu_ctrl, bus.ex_rd);
    else passed++;
    bus.flush = 0;
    bus.stall = 0;
    bus.id_instr = {6'h3F, 5'd1, 5'd2, 16'h1234};
    step();
    bus.id_valid = 0;
    total++;
    if ({bus.ex_valid, bus.ex_illegal, bus.ex_reg_write, bus.alu_ctrl}
        !== {1'b1, 1'b1, 1'b0, 4'h0})
      $display("FAIL illegal got v=%b ill=%b wr=%b op=%h want 1/1/0/0",
               bus.ex_valid, bus.ex_illegal, bus.ex_reg_write, bus.alu_ctrl);
    else passed++;
  endtask

  task automatic test_async_reset();
    bus.id_valid = 1;
    bus.id_instr = {6'h08, 5'd1, 5'd6, 16'h0042};
    bus.id_rs_data = 32'h55;
    step();
    bus.id_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    mclear();
    total++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.alu_a, bus.alu_b} !== 66'h0)
      $display("FAIL async_reset got v=%b a=%h b=%h want 0",
               bus.ex_valid, bus.alu_a, bus.alu_b);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.id_valid = $urandom_range(0, 9) != 0;
      bus.id_instr = rnd_instr();
      bus.id_rs_data = $urandom;
      bus.id_rt_data = $urandom;
      bus.stall = $urandom_range(0, 7) == 0;
      bus.flush = $urandom_range(0, 9) == 0;
      bus.exmem_reg_write = 1'($urandom);
      bus.exmem_rd = 5'($urandom_range(0, 3));
      bus.exmem_result = $urandom;
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_rd = 5'($urandom_range(0, 3));
      bus.memwb_result = $urandom;
      #1;
      total++;
      if (actual() !== mexp())
        $display("FAIL random[%0d] got %h want %h", i, actual(), mexp());
      else passed++;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_forwarding();
    test_load_use();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core, directly upstream of the ALU. It decodes the ID-stage instruction into the 4-bit ALU operation and side controls, then registers operands and controls on the clock edge. In EX it drives the ALU's `A`, `B` and `ALUControl` inputs, applying EX/MEM and MEM/WB forwarding. It also raises the load-use hazard stall.

## Interface
- `XLEN`, 32: datapath width.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the stage register.
- `flush` in 1: load a bubble.
- `id_valid` in 1: ID instruction is valid.
- `id_instr` in 32: ID instruction word.
- `id_rs_data`, `id_rt_data` in XLEN: register-file read data. The register file bypasses same-cycle WB writes internally.
- `exmem_reg_write` in 1: EX/MEM instruction writes a register.
- `exmem_rd` in 5: EX/MEM destination register.
- `exmem_result` in XLEN: EX/MEM ALU result.
- `memwb_reg_write` in 1: MEM/WB instruction writes a register.
- `memwb_rd` in 5: MEM/WB destination register.
- `memwb_result` in XLEN: MEM/WB writeback data.
- `alu_a`, `alu_b` out XLEN: ALU operands.
- `alu_ctrl` out 4: ALU operation. 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL (B<<A), 0101 SRL (B>>A), 0110 SLT.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` out 1: EX-stage controls.
- `ex_rd` out 5: EX destination register.
- `ex_store_data` out XLEN: forwarded rt value for stores.
- `ex_illegal` out 1: undecodable instruction in EX.
- `hazard_stall` out 1: combinational request to stall IF/ID and flush this stage.

## Operation
- Decode (combinational on `id_instr`):
  - R-type, funct 0x20/0x21 → ADD; 0x22/0x23 → SUB; 0x24 → AND; 0x25 → OR; 0x2A → SLT. rd is the destination.
  - R-type, funct 0x00 → SLL; 0x02 → SRL. For shifts, A = zero-extended shamt and B = rt.
  - I-type: addi/addiu, lw (0x23, mem_read), sw (0x2B, mem_write, no reg_write) → ADD with sign-extended imm. andi → AND and ori → OR, both with zero-extended imm. slti → SLT with sign-extended imm. beq/bne → SUB of rs, rt, branch=1, no reg_write. rt is the destination for I-type writes.
  - Any other opcode/funct → `illegal`=1, all writes/mem controls 0, alu_ctrl 0000.
  - A destination of register 0 forces reg_write=0.
- Stage register, rising edge, priority order:
  - `flush`: loads a bubble (valid=0, all controls 0).
  - else `stall`: holds.
  - else loads the decoded fields, `id_rs_data`/`id_rt_data`, imm, shamt and src-selects. `id_valid`=0 loads a bubble.
- Forwarding (EX, combinational on the registered rs/rt indices and data):
  - EX/MEM match (reg_write && rd==src && src!=0) takes priority over a MEM/WB match; otherwise the registered data is used.
  - `alu_a` = shamt for shifts, else forwarded rs.
  - `alu_b` = imm for I-type ALU ops, else forwarded rt.
  - `ex_store_data` = forwarded rt.
- Hazard: `hazard_stall` = `ex_valid && ex_mem_read && ex_rd!=0 && ex_rd` matches a source ID actually reads (rs, or rt for R-type/beq/bne/sw).

## Timing
- Reset: every registered field and output is 0. `alu_ctrl`=0000, `alu_a`=`alu_b`=0, `hazard_stall`=0.
- Latency: 1 cycle from ID to EX outputs. Forwarding adds no cycles.
- `flush` and `stall` together: flush wins.
- Reset asserted mid-instruction clears the stage immediately (asynchronously). No state survives.
- Load-use: one bubble is inserted. On the next cycle MEM/WB forwarding supplies the load data.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding as described.
- Undefined:
  - Forwarding inputs are ignored; operands come from the registered data.
  - `hazard_stall` also asserts on any RAW match against an EX destination (`ex_reg_write`) or an EX/MEM destination (`exmem_reg_write`, `exmem_rd`).

## Structure
- `mips_pkg`: ALU-op localparams (ALU_ADD..ALU_SLT), opcode/funct constants, and the ID/EX control struct typedef.
- Sub-module `alu_decoder`: purely combinational decode of opcode/funct into alu_ctrl, src-selects, imm-extend mode, reg_write/mem/branch/illegal.

## Test plan
- Reset, then `add $3,$1,$2` with rs=5, rt=7 → next cycle alu_ctrl=0000, alu_a=5, alu_b=7, ex_rd=3, ex_reg_write=1.
- `sll $4,$2,3` with rt=0x1 → alu_ctrl=0100, alu_a=3, alu_b=0x1.
- `andi $5,$1,0xFFFF` → alu_b=0x0000FFFF. `slti $5,$1,-1` → alu_b=0xFFFFFFFF, alu_ctrl=0110.
- Forwarding: EX/MEM rd=1 result=0x10 and MEM/WB rd=1 result=0x20 at once → alu_a=0x10. Same case with rd=0 → registered data is used.
- `lw $2,0($1)` then `add $3,$2,$2` → hazard_stall=1 for one cycle and a bubble enters EX. The add then gets the MEM/WB value.
- flush and stall asserted together → ex_valid=0 and all controls 0. Opcode 0x3F → ex_illegal=1, ex_reg_write=0.
